nios_mul_pipe_unit: RTL

//  Parametrised, pipelined integer multiply unit for the Nios custom datapath.

---
 rtl/nios_mul_pkg.sv | 28 ++
 rtl/nios_mul_pp_stage.sv | 21 ++
 rtl/nios_mul_pipe_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/nios_mul_pkg.sv
// Shared definitions for the Nios pipelined multiply unit: op encodings,
// operand signedness decode and the legal latency range.
package nios_mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXSS = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXUU = 2'b11
    } mul_op_e;

    localparam int LAT_MIN = 2;
    localparam int LAT_MAX = 5;

    function automatic logic is_signed_a(input logic [1:0] op);
        return (op == OP_MULXSS) || (op == OP_MULXSU);
    endfunction

    function automatic logic is_signed_b(input logic [1:0] op);
        return (op == OP_MULXSS);
    endfunction

    // MUL returns the low half, all MULX variants the high half.
    function automatic logic is_high_half(input logic [1:0] op);
        return (op != OP_MUL);
    endfunction

endpackage

// File: rtl/nios_mul_pp_stage.sv
// Registered unsigned H x H partial-product multiplier; one instance per DSP block.
module nios_mul_pp_stage #(
    parameter int H = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic [H-1:0]   a,
    input  logic [H-1:0]   b,
    output logic [2*H-1:0] p
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p <= '0;
        end else if (en) begin
            p <= {{H{1'b0}}, a} * {{H{1'b0}}, b};
        end
    end

endmodule

// File: rtl/nios_mul_pipe_unit.sv
// Pipelined integer multiply unit: four registered partial products, a summing and
// sign-correction stage, then plain delay stages up to LAT, all under one stall enable.
module nios_mul_pipe_unit
    import nios_mul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LAT    = 2,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int H  = DATA_W / 2;
    localparam int PW = 2 * DATA_W;

    if (DATA_W < 8 || DATA_W > 64 || (DATA_W % 2) != 0) begin : g_bad_data_w
        $error("nios_mul_pipe_unit: DATA_W must be even and within 8..64");
    end
    if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
        $error("nios_mul_pipe_unit: LAT must be within 2..5");
    end

    logic              adv;
    logic              in_fire;
    logic [LAT:1]      vld_q;
    logic [TAG_W-1:0]  tag_q [1:LAT];
    logic [DATA_W-1:0] res_q [2:LAT];
    logic [DATA_W-1:0] a1_q;
    logic [DATA_W-1:0] b1_q;
    logic              sa1_q;
    logic              sb1_q;
    logic              hi1_q;
    logic [DATA_W-1:0] pp_ll;
    logic [DATA_W-1:0] pp_hl;
    logic [DATA_W-1:0] pp_lh;
    logic [DATA_W-1:0] pp_hh;
    logic [PW-1:0]     prod_w;
    logic [DATA_W-1:0] half_w;

    // Whole pipe moves together; it only stalls when a finished result is refused.
    assign adv      = ~vld_q[LAT] | out_ready;
    assign in_ready = adv & ~flush;
    assign in_fire  = in_valid & in_ready;

    nios_mul_pp_stage #(.H(H)) u_pp_ll (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (adv),
        .a       (in_src1[H-1:0]),
        .b       (in_src2[H-1:0]),
        .p       (pp_ll)
    );

    nios_mul_pp_stage #(.H(H)) u_pp_hl (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (adv),
        .a       (in_src1[DATA_W-1:H]),
        .b       (in_src2[H-1:0]),
        .p       (pp_hl)
    );

    nios_mul_pp_stage #(.H(H)) u_pp_lh (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (adv),
        .a       (in_src1[H-1:0]),
        .b       (in_src2[DATA_W-1:H]),
        .p       (pp_lh)
    );

    nios_mul_pp_stage #(.H(H)) u_pp_hh (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (adv),
        .a       (in_src1[DATA_W-1:H]),
        .b       (in_src2[DATA_W-1:H]),
        .p       (pp_hh)
    );

    // Operands travel alongside the partial products for the sign correction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a1_q  <= '0;
            b1_q  <= '0;
            sa1_q <= 1'b0;
            sb1_q <= 1'b0;
            hi1_q <= 1'b0;
        end else if (adv) begin
            a1_q  <= in_src1;
            b1_q  <= in_src2;
            sa1_q <= is_signed_a(in_op);
            sb1_q <= is_signed_b(in_op);
            hi1_q <= is_high_half(in_op);
        end
    end

    // A negative signed operand weighs -2^DATA_W more than its unsigned reading,
    // so the other operand shifted up is removed; the both-negative term wraps away.
    always_comb begin
        prod_w = {{DATA_W{1'b0}}, pp_ll}
               + ({{DATA_W{1'b0}}, pp_hl} << H)
               + ({{DATA_W{1'b0}}, pp_lh} << H)
               + {pp_hh, {DATA_W{1'b0}}};
        if (sa1_q && a1_q[DATA_W-1]) begin
            prod_w = prod_w - {b1_q, {DATA_W{1'b0}}};
        end
        if (sb1_q && b1_q[DATA_W-1]) begin
            prod_w = prod_w - {a1_q, {DATA_W{1'b0}}};
        end
        half_w = hi1_q ? prod_w[PW-1:DATA_W] : prod_w[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= {vld_q[LAT-1:1], in_fire};
        end
    end

    // Data registers are not cleared by flush; the valid chain alone kills ops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k <= LAT; k++) begin
                tag_q[k] <= '0;
            end
            for (int k = 2; k <= LAT; k++) begin
                res_q[k] <= '0;
            end
        end else if (adv) begin
            tag_q[1] <= in_tag;
            for (int k = 2; k <= LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            res_q[2] <= half_w;
            for (int k = 3; k <= LAT; k++) begin
                res_q[k] <= res_q[k-1];
            end
        end
    end

    assign out_valid  = vld_q[LAT];
    assign out_result = res_q[LAT];
    assign out_tag    = tag_q[LAT];

endmodule
